// File: rtl/agg_seq_pkg.sv
// Shared types and lane arithmetic helpers for the aggregation sequencer.
package agg_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } agg_state_e;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_MAX = 1'b1
  } agg_op_e;

  localparam int unsigned LANE_W_DEFAULT = 8;
  localparam int          LANE_MAX       = (2 ** (LANE_W_DEFAULT - 1)) - 1;
  localparam int          LANE_MIN       = -(2 ** (LANE_W_DEFAULT - 1));

  // Sign-extended operands in, result clamped to [lo, hi].
  function automatic int sat_add(input int a, input int b,
                                 input int lo = LANE_MIN, input int hi = LANE_MAX);
    longint s;
    s = 64'(a) + 64'(b);
    if (s > 64'(hi)) return hi;
    if (s < 64'(lo)) return lo;
    return 32'(s);
  endfunction

endpackage

// File: rtl/agg_seq_ctrl_if.sv
// Command and scratchpad bus of the aggregation sequencer.
interface agg_seq_ctrl_if #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned PARALLELISM = 1,
  parameter int unsigned HEIGHT      = 128
);
  localparam int unsigned AW = $clog2(HEIGHT);
  localparam int unsigned RW = PARALLELISM * WIDTH;

  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_src_a;
  logic [AW-1:0] cmd_src_b;
  logic [AW-1:0] cmd_dst;
  logic [AW:0]   cmd_len;
  logic          cmd_op;
  logic          busy;
  logic          done;
  logic          spad_cs;
  logic [AW-1:0] spad_read_addr_1;
  logic [AW-1:0] spad_read_addr_2;
  logic          spad_read_en_1;
  logic          spad_read_en_2;
  logic [RW-1:0] spad_qout_1;
  logic [RW-1:0] spad_qout_2;
  logic [AW-1:0] spad_write_addr;
  logic          spad_write_en;
  logic [RW-1:0] spad_din;

  modport master (
    output cmd_valid, cmd_src_a, cmd_src_b, cmd_dst, cmd_len, cmd_op,
           spad_qout_1, spad_qout_2,
    input  cmd_ready, busy, done, spad_cs,
           spad_read_addr_1, spad_read_addr_2, spad_read_en_1, spad_read_en_2,
           spad_write_addr, spad_write_en, spad_din
  );

  modport slave (
    input  cmd_valid, cmd_src_a, cmd_src_b, cmd_dst, cmd_len, cmd_op,
           spad_qout_1, spad_qout_2,
    output cmd_ready, busy, done, spad_cs,
           spad_read_addr_1, spad_read_addr_2, spad_read_en_1, spad_read_en_2,
           spad_write_addr, spad_write_en, spad_din
  );

endinterface

// File: rtl/agg_lane_alu.sv
// One signed lane: saturating add or signed max, purely combinational.
module agg_lane_alu
  import agg_seq_pkg::*;
#(
  parameter int unsigned WIDTH = LANE_W_DEFAULT
) (
  input  logic signed [WIDTH-1:0] i_a,
  input  logic signed [WIDTH-1:0] i_b,
  input  agg_op_e                 i_op,
  output logic signed [WIDTH-1:0] o_y_c
);
  localparam int LO = -(2 ** (WIDTH - 1));
  localparam int HI = (2 ** (WIDTH - 1)) - 1;

  int w_sum;

  always_comb begin
    w_sum = sat_add(32'(i_a), 32'(i_b), LO, HI);
    o_y_c = WIDTH'(w_sum);
    if (i_op == OP_MAX) begin
      o_y_c = (i_a > i_b) ? i_a : i_b;
    end
  end

endmodule

// File: rtl/agg_seq_ctrl.sv
// Command-driven row sequencer: streams len row pairs through the lane ALUs into dst.
// Optional AGG_SEQ_PERF_EN adds busy-cycle and completed-command counters.
module agg_seq_ctrl
  import agg_seq_pkg::*;
#(
  parameter int unsigned WIDTH       = LANE_W_DEFAULT,
  parameter int unsigned PARALLELISM = 1,
  parameter int unsigned HEIGHT      = 128
) (
  input  logic                clk,
  input  logic                rst,
  agg_seq_ctrl_if.slave       bus
`ifdef AGG_SEQ_PERF_EN
  ,
  output logic [31:0]         perf_busy_cycles,
  output logic [15:0]         perf_cmds
`endif
);
  localparam int unsigned AW = $clog2(HEIGHT);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned RW = PARALLELISM * WIDTH;

  localparam logic [1:0] S_IDLE  = 2'(IDLE);
  localparam logic [1:0] S_RUN   = 2'(RUN);
  localparam logic [1:0] S_DRAIN = 2'(DRAIN);

  logic [1:0]    r_state;
  logic [1:0]    w_next_state;
  logic          w_accept;

  logic [LW-1:0] r_len_left;
  agg_op_e       r_op;
  logic [AW-1:0] r_rd_addr_1;
  logic [AW-1:0] r_rd_addr_2;
  logic [AW-1:0] r_dst_addr;
  logic          r_wr_valid;
  logic [AW-1:0] r_wr_addr;
  logic [RW-1:0] r_wr_data;
  logic          r_cmd_ready;
  logic          r_active;
  logic          r_rd_en;
  logic          r_done;

  logic [RW-1:0] w_op_a;
  logic [RW-1:0] w_op_b;
  logic [RW-1:0] w_result;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.cmd_valid && r_cmd_ready) begin
          w_accept = 1'b1;
          if (bus.cmd_len != '0) w_next_state = S_RUN;
        end
      end
      S_RUN:   if (r_len_left == LW'(1)) w_next_state = S_DRAIN;
      S_DRAIN: w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // The row in the write stage lands in the scratchpad this cycle, so a read of it must see it now.
  assign w_op_a = (r_wr_valid && (r_wr_addr == r_rd_addr_1)) ? r_wr_data : bus.spad_qout_1;
  assign w_op_b = (r_wr_valid && (r_wr_addr == r_rd_addr_2)) ? r_wr_data : bus.spad_qout_2;

  for (genvar l = 0; l < PARALLELISM; l++) begin : g_lane
    agg_lane_alu #(.WIDTH(WIDTH)) u_alu (
      .i_a   (w_op_a[l*WIDTH +: WIDTH]),
      .i_b   (w_op_b[l*WIDTH +: WIDTH]),
      .i_op  (r_op),
      .o_y_c (w_result[l*WIDTH +: WIDTH])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_len_left  <= '0;
      r_op        <= OP_ADD;
      r_rd_addr_1 <= '0;
      r_rd_addr_2 <= '0;
      r_dst_addr  <= '0;
      r_wr_valid  <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_cmd_ready <= 1'b1;
      r_active    <= 1'b0;
      r_rd_en     <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_cmd_ready <= (w_next_state == S_IDLE);
      r_active    <= (w_next_state != S_IDLE);
      r_rd_en     <= (w_next_state == S_RUN);
      r_done      <= (w_next_state == S_DRAIN) || (w_accept && (bus.cmd_len == '0));
      r_wr_valid  <= (r_state == S_RUN);
      if (r_state == S_RUN) begin
        r_wr_addr <= r_dst_addr;
        r_wr_data <= w_result;
      end
      // Addresses wrap naturally at AW bits since HEIGHT is a power of two.
      if (w_accept) begin
        r_rd_addr_1 <= bus.cmd_src_a;
        r_rd_addr_2 <= bus.cmd_src_b;
        r_dst_addr  <= bus.cmd_dst;
        r_len_left  <= bus.cmd_len;
        r_op        <= agg_op_e'(bus.cmd_op);
      end else if (r_state == S_RUN) begin
        r_rd_addr_1 <= r_rd_addr_1 + AW'(1);
        r_rd_addr_2 <= r_rd_addr_2 + AW'(1);
        r_dst_addr  <= r_dst_addr + AW'(1);
        r_len_left  <= r_len_left - LW'(1);
      end
    end
  end

  assign bus.cmd_ready        = r_cmd_ready;
  assign bus.busy             = r_active;
  assign bus.done             = r_done;
  assign bus.spad_cs          = r_active;
  assign bus.spad_read_en_1   = r_rd_en;
  assign bus.spad_read_en_2   = r_rd_en;
  assign bus.spad_read_addr_1 = r_rd_addr_1;
  assign bus.spad_read_addr_2 = r_rd_addr_2;
  assign bus.spad_write_en    = r_wr_valid;
  assign bus.spad_write_addr  = r_wr_addr;
  assign bus.spad_din         = r_wr_data;

`ifdef AGG_SEQ_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_busy_cycles <= '0;
      perf_cmds        <= '0;
    end else begin
      if (r_active) perf_busy_cycles <= perf_busy_cycles + 32'd1;
      if (r_done)   perf_cmds        <= perf_cmds + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_agg_seq_ctrl.sv
// Bench for agg_seq_ctrl: scratchpad model, command-level reference and per-cycle output compare.
module tb_agg_seq_ctrl;
  localparam int unsigned W = 8;
  localparam int unsigned P = 1;
  localparam int unsigned H = 128;

  logic clk;
  logic rst;

  agg_seq_ctrl_if #(.WIDTH(W), .PARALLELISM(P), .HEIGHT(H)) bus ();

`ifdef AGG_SEQ_PERF_EN
  logic [31:0] perf_busy_cycles;
  logic [15:0] perf_cmds;
`endif

  agg_seq_ctrl #(.WIDTH(W), .PARALLELISM(P), .HEIGHT(H)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef AGG_SEQ_PERF_EN
    ,
    .perf_busy_cycles (perf_busy_cycles),
    .perf_cmds        (perf_cmds)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scratchpad macro: 0-cycle reads, writes at the clock edge, plus a bench preload port.
  logic [7:0] spad [H];
  logic       pl_en = 1'b0;
  logic [6:0] pl_addr = '0;
  logic [7:0] pl_data = '0;

  assign bus.spad_qout_1 = spad[bus.spad_read_addr_1];
  assign bus.spad_qout_2 = spad[bus.spad_read_addr_2];

  always @(posedge clk) begin
    if (pl_en) spad[pl_addr] <= pl_data;
    else if (bus.spad_cs && bus.spad_write_en) spad[bus.spad_write_addr] <= bus.spad_din;
  end

  typedef struct {
    bit         busy, done, ready, rd_en, wr_en;
    logic [6:0] ra1, ra2, wa;
    logic [7:0] wd;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] mdl [H];
  int         checks = 0;
  int         errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [7:0] lane_op(input logic [7:0] a, input logic [7:0] b, input bit op);
    int sa, sb, s;
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (op) return (sa > sb) ? a : b;
    s = sa + sb;
    if (s > 127)  s = 127;
    if (s < -128) s = -128;
    return 8'(s);
  endfunction

  // Applies a whole command to the model memory in row order and queues the cycle-by-cycle outputs.
  task automatic push_expect(input logic [6:0] sa, input logic [6:0] sb, input logic [6:0] dst,
                             input int len, input bit op);
    logic [7:0] res[$];
    exp_t e;
    for (int i = 0; i < len; i++) begin
      logic [7:0] r;
      r = lane_op(mdl[7'(int'(sa) + i)], mdl[7'(int'(sb) + i)], op);
      mdl[7'(int'(dst) + i)] = r;
      res.push_back(r);
    end
    if (len == 0) begin
      e = '{busy: 1'b0, done: 1'b1, ready: 1'b1, rd_en: 1'b0, wr_en: 1'b0,
            ra1: '0, ra2: '0, wa: '0, wd: '0};
      exp_q.push_back(e);
    end else begin
      for (int k = 1; k <= len + 1; k++) begin
        e.busy  = 1'b1;
        e.ready = 1'b0;
        e.done  = (k == len + 1);
        e.rd_en = (k <= len);
        e.ra1   = 7'(int'(sa) + k - 1);
        e.ra2   = 7'(int'(sb) + k - 1);
        e.wr_en = (k >= 2);
        e.wa    = 7'(int'(dst) + k - 2);
        e.wd    = (k >= 2) ? res[k-2] : 8'h00;
        exp_q.push_back(e);
      end
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (exp_q.size() != 0) e = exp_q.pop_front();
      else e = '{busy: 1'b0, done: 1'b0, ready: 1'b1, rd_en: 1'b0, wr_en: 1'b0,
                 ra1: '0, ra2: '0, wa: '0, wd: '0};
      chk("busy",      32'(bus.busy),           32'(e.busy));
      chk("cs",        32'(bus.spad_cs),        32'(e.busy));
      chk("done",      32'(bus.done),           32'(e.done));
      chk("cmd_ready", 32'(bus.cmd_ready),      32'(e.ready));
      chk("rd_en_1",   32'(bus.spad_read_en_1), 32'(e.rd_en));
      chk("rd_en_2",   32'(bus.spad_read_en_2), 32'(e.rd_en));
      chk("wr_en",     32'(bus.spad_write_en),  32'(e.wr_en));
      if (e.rd_en) begin
        chk("rd_addr_1", 32'(bus.spad_read_addr_1), 32'(e.ra1));
        chk("rd_addr_2", 32'(bus.spad_read_addr_2), 32'(e.ra2));
      end
      if (e.wr_en) begin
        chk("wr_addr", 32'(bus.spad_write_addr), 32'(e.wa));
        chk("wr_data", 32'(bus.spad_din),        32'(e.wd));
      end
    end
  end

  task automatic preload(input logic [6:0] a, input logic [7:0] d);
    @(negedge clk); #1;
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    mdl[a] = d;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  task automatic issue(input logic [6:0] sa, input logic [6:0] sb, input logic [6:0] dst,
                       input int len, input bit op, input bit hold, output int acc_cyc);
    int n;
    n = 0;
    @(negedge clk); #1;
    bus.cmd_valid = 1'b1;
    bus.cmd_src_a = sa;
    bus.cmd_src_b = sb;
    bus.cmd_dst   = dst;
    bus.cmd_len   = 8'(len);
    bus.cmd_op    = op;
    while (!bus.cmd_ready && n < 400) begin
      @(negedge clk); #1;
      n++;
    end
    acc_cyc = cyc;
    if (!bus.cmd_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: cmd_ready stayed 0 for %0d cycles", n);
      bus.cmd_valid = 1'b0;
      return;
    end
    push_expect(sa, sb, dst, len, op);
    @(posedge clk); #1;
    if (!hold) bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge clk); #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL completion_timeout: %0d expected cycles left", exp_q.size());
      exp_q.delete();
    end
    @(negedge clk); #1;
  endtask

  int a1, a2;

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_src_a = '0;
    bus.cmd_src_b = '0;
    bus.cmd_dst   = '0;
    bus.cmd_len   = '0;
    bus.cmd_op    = 1'b0;
    rst = 1'b0;
    #1 rst = 1'b1;
    #2;
    chk("reset_cmd_ready", 32'(bus.cmd_ready),     32'd1);
    chk("reset_busy",      32'(bus.busy),          32'd0);
    chk("reset_wr_en",     32'(bus.spad_write_en), 32'd0);
    chk("reset_done",      32'(bus.done),          32'd0);
    @(negedge clk); #1;
    rst = 1'b0;

    for (int r = 0; r < int'(H); r++) preload(7'(r), 8'h00);

    // Basic add: rows 16..19 = {11,22,33,44}
    for (int r = 0; r < 4; r++) begin
      preload(7'(r),     8'((r + 1) * 10));
      preload(7'(8 + r), 8'(r + 1));
    end
    issue(7'd0, 7'd8, 7'd16, 4, 1'b0, 1'b0, a1);
    wait_idle();
    chk("add_row16", 32'(spad[16]), 32'd11);
    chk("add_row17", 32'(spad[17]), 32'd22);
    chk("add_row18", 32'(spad[18]), 32'd33);
    chk("add_row19", 32'(spad[19]), 32'd44);

    // Saturation both ways, then signed max
    preload(7'd32, 8'd100);  preload(7'd40, 8'd100);
    preload(7'd33, 8'h9C);   preload(7'd41, 8'h9C);
    preload(7'd34, 8'hFB);   preload(7'd42, 8'd3);
    issue(7'd32, 7'd40, 7'd48, 2, 1'b0, 1'b0, a1);
    wait_idle();
    issue(7'd34, 7'd42, 7'd50, 1, 1'b1, 1'b0, a1);
    wait_idle();
    chk("sat_pos", 32'(spad[48]), 32'h7F);
    chk("sat_neg", 32'(spad[49]), 32'h80);
    chk("max_neg_pos", 32'(spad[50]), 32'd3);

    // Forwarding chain: each result is the next row's operand
    preload(7'd0, 8'd1);
    issue(7'd0, 7'd0, 7'd1, 3, 1'b0, 1'b0, a1);
    wait_idle();
    chk("fwd_row1", 32'(spad[1]), 32'd2);
    chk("fwd_row2", 32'(spad[2]), 32'd4);
    chk("fwd_row3", 32'(spad[3]), 32'd8);

    // Wrap: reads 126,127,0 and writes 127,0,1 (127 and 0 forwarded)
    preload(7'd126, 8'd5);
    preload(7'd127, 8'd50);
    for (int r = 100; r < 103; r++) preload(7'(r), 8'd1);
    issue(7'd126, 7'd100, 7'd127, 3, 1'b0, 1'b0, a1);
    wait_idle();
    chk("wrap_row127", 32'(spad[127]), 32'd6);
    chk("wrap_row0",   32'(spad[0]),   32'd7);
    chk("wrap_row1",   32'(spad[1]),   32'd8);

    // Zero-length command
    issue(7'd5, 7'd5, 7'd5, 0, 1'b0, 1'b0, a1);
    wait_idle();
    chk("len0_row5", 32'(spad[5]), 32'd0);

    // Back-to-back with valid held high
    issue(7'd0, 7'd8, 7'd70, 3, 1'b0, 1'b1, a1);
    issue(7'd8, 7'd0, 7'd80, 2, 1'b1, 1'b0, a2);
    chk("b2b_accept_gap", 32'(a2 - a1), 32'd5);
    wait_idle();

    // Full-height command doubles every row in place
    issue(7'd0, 7'd0, 7'd0, int'(H), 1'b0, 1'b0, a1);
    wait_idle();
    chk("full_row16", 32'(spad[16]), 32'd22);

    // Reset in the middle of a run
    issue(7'd0, 7'd8, 7'd90, 20, 1'b1, 1'b0, a1);
    repeat (3) @(posedge clk);
    #1;
    chk("pre_rst_wr_en", 32'(bus.spad_write_en), 32'd1);
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("rst_wr_en",     32'(bus.spad_write_en), 32'd0);
    chk("rst_cs",        32'(bus.spad_cs),       32'd0);
    chk("rst_cmd_ready", 32'(bus.cmd_ready),     32'd1);
    chk("rst_done",      32'(bus.done),          32'd0);
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    repeat (6) @(negedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
